innerproduct_mac: RTL

Parametrised, time-multiplexed inner-product engine for the logistic-regression datapath. It accepts a feature vector streamed LANES features per beat and multiplies each feature by its coefficient from an external theta ROM. Products are accumulated with an implicit fixed-point bias term, and one `hidden` result is emitted per vector over a valid/ready handshake. It sits between the line buffer (feature source) and the sigmoid/threshold stage, replacing fixed fully-parallel dot products.

---
 rtl/innerproduct_mac.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/innerproduct_mac.sv
// innerproduct_mac: time-multiplexed signed inner product of a streamed
// unsigned feature vector against a theta ROM, with an implicit bias term
// in slot 0. A result is emitted on a valid/ready handshake.

// One multiplier lane: registers theta*x, truncated or sign-extended to ACCW.
module ipm_lane #(
  parameter int XEW  = 32,
  parameter int TW   = 32,
  parameter int ACCW = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   ld,
  input  logic                   kill,
  input  logic [XEW-1:0]         x,
  input  logic signed [TW-1:0]   th,
  output logic [ACCW-1:0]        prod
);
  localparam int PW = XEW + 1 + TW;

  logic signed [PW-1:0]   full;
  logic signed [ACCW-1:0] p;

  // x is unsigned, so it gets a zero sign bit before the signed multiply
  always_comb begin
    full = $signed({1'b0, x}) * th;
    p    = ACCW'(full);
  end

  // product register; padded lanes load zero so they never contribute
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      prod <= '0;
    else if (clr) prod <= '0;
    else if (ld)  prod <= kill ? '0 : p;
  end
endmodule

module innerproduct_mac #(
  parameter int N_FEAT   = 81,
  parameter int LANES    = 9,
  parameter int XW       = 7,
  parameter int TW       = 32,
  parameter int ACCW     = 32,
  parameter int BIAS_ONE = 65536,
  parameter int SAT      = 0,
  localparam int BEATS   = (N_FEAT + LANES - 1) / LANES,
  localparam int AW      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*XW-1:0]     in_data,
  input  logic                    abort,
  output logic [AW-1:0]           th_addr,
  input  logic [LANES*TW-1:0]     th_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACCW-1:0]  hidden
);
  // multiplicand wide enough for both a feature and the bias constant
  localparam int XEW    = ((XW > 32) ? XW : 32);
  localparam int SW     = ACCW + $clog2(LANES) + 1;
  localparam int STAGES = 1;
  localparam logic signed [SW-1:0] SMAX = {{(SW-ACCW+1){1'b0}}, {(ACCW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = ~SMAX;

  typedef enum logic [1:0] {ACCUM, DRAIN1, DRAIN2, OUT} st_t;

  st_t st, st_nx;

  logic [AW-1:0]              cnt;
  logic                       last;
  logic                       accept;
  logic                       kill_all;
  logic [STAGES:0]            vld_pipe;
  logic [LANES-1:0][ACCW-1:0] prods;
  logic signed [SW-1:0]       tsum;
  logic signed [SW-1:0]       asum;
  logic [ACCW-1:0]            tree;
  logic [ACCW-1:0]            acc;
  logic [ACCW-1:0]            acc_nx;

  // wrap keeps the low ACCW bits; saturation clamps to the signed range
  function automatic logic [ACCW-1:0] clip(input logic signed [SW-1:0] v);
    if (SAT != 0 && v > SMAX) return SMAX[ACCW-1:0];
    if (SAT != 0 && v < SMIN) return SMIN[ACCW-1:0];
    return v[ACCW-1:0];
  endfunction

  assign last     = (cnt == AW'(BEATS-1));
  assign accept   = in_valid & in_ready & ~abort;
  assign kill_all = abort & (st != OUT);
  assign th_addr  = cnt;
  assign vld_pipe[0] = accept;

  // per-lane operand select and multiplier instances
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam bit PAD = ((BEATS-1)*LANES + k) >= N_FEAT;
    logic [XEW-1:0] xs;
    if (k == 0) begin : g_bias
      assign xs = (cnt == '0) ? XEW'(BIAS_ONE) : XEW'(in_data[k*XW +: XW]);
    end else begin : g_feat
      assign xs = XEW'(in_data[k*XW +: XW]);
    end
    ipm_lane #(.XEW(XEW), .TW(TW), .ACCW(ACCW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (kill_all),
      .ld   (accept),
      .kill (PAD & last),
      .x    (xs),
      .th   (th_data[k*TW +: TW]),
      .prod (prods[k])
    );
  end

  // adder tree over the registered products, then the accumulate step
  always_comb begin
    tsum = '0;
    for (int k = 0; k < LANES; k++) tsum = tsum + SW'($signed(prods[k]));
    tree   = clip(tsum);
    asum   = SW'($signed(acc)) + SW'($signed(tree));
    acc_nx = clip(asum);
  end

  // products are summed into acc one cycle after they were registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           vld_pipe[STAGES:1] <= '0;
    else if (kill_all) vld_pipe[STAGES:1] <= '0;
    else               vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  // beat counter doubles as the theta ROM address
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (kill_all) cnt <= '0;
    else if (accept)   cnt <= last ? '0 : cnt + AW'(1);
  end

  // accumulator, cleared once the result has been taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          acc <= '0;
    else if (kill_all)                acc <= '0;
    else if (st == OUT && out_ready)  acc <= '0;
    else if (vld_pipe[STAGES])        acc <= acc_nx;
  end

  // result register, loaded once the final products have landed
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       hidden <= '0;
    else if (st == DRAIN2 && !abort) hidden <= acc;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= ACCUM;
    else     st <= st_nx;
  end

  // next-state logic; abort wins everywhere except while presenting a result
  always_comb begin
    st_nx = st;
    case (st)
      ACCUM:   if (accept && last) st_nx = DRAIN1;
      DRAIN1:  st_nx = DRAIN2;
      DRAIN2:  st_nx = OUT;
      OUT:     if (out_ready) st_nx = ACCUM;
      default: st_nx = ACCUM;
    endcase
    if (kill_all) st_nx = ACCUM;
  end

  // outputs decoded from state only, so out_ready never reaches in_ready
  always_comb begin
    in_ready  = (st == ACCUM) && !rst;
    out_valid = (st == OUT);
  end
endmodule
